// File: rtl/uart_rx_history.sv
// uart_rx_history: oversampling UART receiver feeding a FIFO-deep byte history.
// RX is sampled through a two-flop synchroniser and deserialised LSB first.
// Each good frame shifts the history down and writes the new byte into RXBUF[FIFO-1].
// Optional feature macro: UART_RX_PARITY_EN.
//   Defined   : 8E1 frames with a PARITY state, and parity_err is active.
//   Undefined : 8N1 frames, and parity_err is tied to 0.
module uart_rx_history #(
   parameter int CLKS_PER_BIT = 868,
   parameter int DATA_BITS    = 8,
   parameter int FIFO         = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           RX,
   output logic [0:FIFO-1][DATA_BITS-1:0] RXBUF,
   output logic                           data_available,
   output logic                           frame_err,
   output logic                           parity_err,
   output logic                           rx_busy
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] START  = 3'd1;
   localparam logic [2:0] DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
   localparam logic [2:0] PARITY = 3'd3;
`endif
   localparam logic [2:0] STOP   = 3'd4;
   localparam logic [2:0] BREAK  = 3'd5;

   logic                 rx_meta;
   logic                 rxs;
   logic [2:0]           state;
   logic [CNT_W-1:0]     cnt;
   logic [IDX_W-1:0]     bit_idx;
   logic [DATA_BITS-1:0] shreg;
   logic                 par_mis;

`ifndef UART_RX_PARITY_EN
   // Without parity there is never a mismatch, so the STOP decision reduces to the stop bit.
   assign par_mis    = 1'b0;
   assign parity_err = 1'b0;
`endif

   assign rx_busy = (state != IDLE);

   // Two-flop synchroniser for the asynchronous pin, preset to the idle-high level.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta <= 1'b1;
         rxs     <= 1'b1;
      end else begin
         // NOTE: non-blocking assignments let every flop here sample the pre-edge value,
         // which is what makes this a two-stage chain rather than a single wire.
         rx_meta <= RX;
         rxs     <= rx_meta;
      end
   end

   // Frame FSM: bit timing, deserialisation, history push and the single-cycle status pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         cnt            <= '0;
         bit_idx        <= '0;
         shreg          <= '0;
         // NOTE: the history is cleared on reset because the pager and LEDs show every entry
         // and must not display garbage; it is a few registers, not a RAM.
         RXBUF          <= '0;
         data_available <= 1'b0;
         frame_err      <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_err     <= 1'b0;
         par_mis        <= 1'b0;
`endif
      end else begin
         data_available <= 1'b0;
         frame_err      <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_err     <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (!rxs) begin
                  state <= START;
                  cnt   <= '0;
`ifdef UART_RX_PARITY_EN
                  par_mis <= 1'b0;
`endif
               end
            end

            START: begin
               if (cnt == HALF_CNT) begin
                  cnt <= '0;
                  if (!rxs) begin
                     state   <= DATA;
                     bit_idx <= '0;
                  end else begin
                     // The line rose again before mid start bit, so this was a glitch.
                     state <= IDLE;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            DATA: begin
               if (cnt == LAST_CNT) begin
                  cnt            <= '0;
                  shreg[bit_idx] <= rxs;
                  if (bit_idx == LAST_IDX) begin
                     bit_idx <= '0;
`ifdef UART_RX_PARITY_EN
                     state   <= PARITY;
`else
                     state   <= STOP;
`endif
                  end else begin
                     bit_idx <= bit_idx + 1'b1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

`ifdef UART_RX_PARITY_EN
            PARITY: begin
               if (cnt == LAST_CNT) begin
                  cnt     <= '0;
                  // Even parity: the parity bit must equal the XOR of the data bits.
                  par_mis <= (rxs != ^shreg);
                  state   <= STOP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
`endif

            STOP: begin
               if (cnt == LAST_CNT) begin
                  cnt <= '0;
                  if (rxs) begin
                     state <= IDLE;
                     if (!par_mis) begin
                        for (int i = 0; i < FIFO - 1; i++) begin
                           RXBUF[i] <= RXBUF[i+1];
                        end
                        RXBUF[FIFO-1]  <= shreg;
                        data_available <= 1'b1;
                     end
`ifdef UART_RX_PARITY_EN
                     else begin
                        parity_err <= 1'b1;
                     end
`endif
                  end else begin
                     // A low stop bit is a framing error; wait in BREAK so a held-low line
                     // reports only once.
                     state     <= BREAK;
                     frame_err <= 1'b1;
`ifdef UART_RX_PARITY_EN
                     parity_err <= par_mis;
`endif
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            BREAK: begin
               if (rxs) begin
                  state <= IDLE;
               end
            end

            default: begin
               state <= IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx_history.sv
// Self-checking bench for uart_rx_history with CLKS_PER_BIT=16 and FIFO=4.
// It uses directed vectors from a table, hand-written corner sequences, and random
// frames checked against a queue-based model of the byte history.
// It also builds with UART_RX_PARITY_EN defined, in which case frames carry an even-parity bit.
`timescale 1ns/1ps
module tb_uart_rx_history;

   localparam int CPB  = 16;
   localparam int FIFO = 4;

   logic                  clk = 1'b0;
   logic                  rst = 1'b1;
   logic                  RX  = 1'b1;
   logic [0:FIFO-1][7:0]  RXBUF;
   logic                  data_available;
   logic                  frame_err;
   logic                  parity_err;
   logic                  rx_busy;

   int n_checks = 0;
   int n_pass   = 0;

   // Pulse counters and protocol-rule watcher, sampled on the falling edge.
   int          da_cnt = 0;
   int          fe_cnt = 0;
   int          pe_cnt = 0;
   int          rule_viol = 0;
   logic        prev_da = 1'b0;
   logic        prev_fe = 1'b0;
   logic        prev_pe = 1'b0;
   logic [31:0] prev_buf = '0;

   // Every byte that should have been pushed since the last reset, oldest first.
   logic [7:0] pushed[$];

   always #5 clk = ~clk;

   uart_rx_history #(
      .CLKS_PER_BIT(CPB),
      .DATA_BITS   (8),
      .FIFO        (FIFO)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .RX            (RX),
      .RXBUF         (RXBUF),
      .data_available(data_available),
      .frame_err     (frame_err),
      .parity_err    (parity_err),
      .rx_busy       (rx_busy)
   );

   // Count pulses and flag rule breaks: no pulse on two consecutive cycles, data_available
   // exclusive with the error pulses, and the history never changes without data_available.
   always @(negedge clk) begin
      if (data_available) da_cnt++;
      if (frame_err)      fe_cnt++;
      if (parity_err)     pe_cnt++;
      if ((data_available && prev_da) || (frame_err && prev_fe) || (parity_err && prev_pe))
         rule_viol++;
      if (data_available && (frame_err || parity_err))
         rule_viol++;
      if (!rst && (RXBUF != prev_buf) && !data_available)
         rule_viol++;
      prev_da  = data_available;
      prev_fe  = frame_err;
      prev_pe  = parity_err;
      prev_buf = RXBUF;
   end

   // Bound on total simulation time.
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h required %0h", name, act, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive_bit(input logic v, input int n);
      RX = v;
      tick(n);
   endtask

   // One whole frame. stop is the stop-bit level; par_bad inverts the parity bit.
   task automatic send_frame(input logic [7:0] data, input logic stop, input logic par_bad);
      drive_bit(1'b0, CPB);
      for (int i = 0; i < 8; i++) drive_bit(data[i], CPB);
`ifdef UART_RX_PARITY_EN
      drive_bit((^data) ^ par_bad, CPB);
`else
      if (par_bad) $display("note: parity error requested in an 8N1 build, ignored");
`endif
      drive_bit(stop, CPB);
      RX = 1'b1;
   endtask

   // Expected history: the last FIFO pushed bytes, the newest in the least-significant byte.
   function automatic logic [31:0] model_buf();
      logic [31:0] r;
      int          k;
      r = '0;
      for (int i = 0; i < FIFO; i++) begin
         k = pushed.size() - FIFO + i;
         if (k >= 0) r[31 - 8*i -: 8] = pushed[k];
      end
      return r;
   endfunction

   typedef struct {
      logic [7:0]  data;
      logic        stop;
      int          gap;
      int          exp_da;
      int          exp_fe;
      logic [31:0] exp_buf;
   } vec_t;

   vec_t vecs[7];

   initial begin
      int          da0, fe0, pe0;
      logic [7:0]  d;
      logic        stop_ok, par_bad;
      int          gap;

      vecs[0] = '{8'hA5, 1'b1, 4, 1, 0, 32'h0000_00A5};
      vecs[1] = '{8'h11, 1'b1, 0, 1, 0, 32'h0000_A511};
      vecs[2] = '{8'h22, 1'b1, 0, 1, 0, 32'h00A5_1122};
      vecs[3] = '{8'h33, 1'b1, 0, 1, 0, 32'hA511_2233};
      vecs[4] = '{8'h44, 1'b1, 0, 1, 0, 32'h1122_3344};
      vecs[5] = '{8'h55, 1'b1, 4, 1, 0, 32'h2233_4455};
      vecs[6] = '{8'h66, 1'b0, 8, 0, 1, 32'h2233_4455};

      // Reset state.
      rst = 1'b1;
      RX  = 1'b1;
      tick(3);
      check("reset_rxbuf", RXBUF, 32'h0);
      check("reset_data_available", 32'(data_available), 32'h0);
      check("reset_frame_err", 32'(frame_err), 32'h0);
      check("reset_parity_err", 32'(parity_err), 32'h0);
      check("reset_rx_busy", 32'(rx_busy), 32'h0);
      rst = 1'b0;
      tick(4);

      // Directed table: a single byte, back-to-back frames that overflow the history,
      // and a bad stop bit.
      for (int v = 0; v < 7; v++) begin
         da0 = da_cnt;
         fe0 = fe_cnt;
         send_frame(vecs[v].data, vecs[v].stop, 1'b0);
         tick(vecs[v].gap);
         check($sformatf("vec%0d_data_available", v), 32'(da_cnt - da0), 32'(vecs[v].exp_da));
         check($sformatf("vec%0d_frame_err", v), 32'(fe_cnt - fe0), 32'(vecs[v].exp_fe));
         check($sformatf("vec%0d_rxbuf", v), RXBUF, vecs[v].exp_buf);
         check($sformatf("vec%0d_rx_busy", v), 32'(rx_busy), 32'h0);
      end
      pushed = '{8'h22, 8'h33, 8'h44, 8'h55};

      // Start-bit glitch: low for 5 cycles, then high again.
      da0 = da_cnt;
      fe0 = fe_cnt;
      RX = 1'b0;
      tick(5);
      check("glitch_busy_in_start", 32'(rx_busy), 32'h1);
      RX = 1'b1;
      tick(20);
      check("glitch_data_available", 32'(da_cnt - da0), 32'h0);
      check("glitch_frame_err", 32'(fe_cnt - fe0), 32'h0);
      check("glitch_rx_busy", 32'(rx_busy), 32'h0);
      check("glitch_rxbuf", RXBUF, model_buf());

      // Break: a bad stop bit on 0x3C, then the line held low for 40 bit times.
      da0 = da_cnt;
      fe0 = fe_cnt;
      send_frame(8'h3C, 1'b0, 1'b0);
      RX = 1'b0;
      tick(20 * CPB);
      check("break_busy_held", 32'(rx_busy), 32'h1);
      tick(20 * CPB);
      RX = 1'b1;
      tick(10);
      check("break_frame_err_once", 32'(fe_cnt - fe0), 32'h1);
      check("break_no_push", 32'(da_cnt - da0), 32'h0);
      check("break_rx_busy", 32'(rx_busy), 32'h0);
      check("break_rxbuf", RXBUF, model_buf());

      // Reset in the middle of bit 4 of 0x7E, then a clean 0x81.
      d = 8'h7E;
      drive_bit(1'b0, CPB);
      for (int i = 0; i < 4; i++) drive_bit(d[i], CPB);
      drive_bit(d[4], CPB / 2);
      check("midframe_busy", 32'(rx_busy), 32'h1);
      da0 = da_cnt;
      fe0 = fe_cnt;
      rst = 1'b1;
      RX  = 1'b1;
      tick(2);
      check("midframe_reset_rxbuf", RXBUF, 32'h0);
      check("midframe_reset_busy", 32'(rx_busy), 32'h0);
      rst = 1'b0;
      tick(2 * CPB);
      check("midframe_no_pulse", 32'((da_cnt - da0) + (fe_cnt - fe0)), 32'h0);
      pushed.delete();
      da0 = da_cnt;
      send_frame(8'h81, 1'b1, 1'b0);
      pushed.push_back(8'h81);
      tick(2);
      check("after_reset_push", 32'(da_cnt - da0), 32'h1);
      check("after_reset_rxbuf", RXBUF, 32'h0000_0081);

`ifdef UART_RX_PARITY_EN
      // Parity: 0x03 with a wrong parity bit (1), then with the correct one (0).
      da0 = da_cnt;
      pe0 = pe_cnt;
      send_frame(8'h03, 1'b1, 1'b1);
      tick(2);
      check("parity_bad_pulse", 32'(pe_cnt - pe0), 32'h1);
      check("parity_bad_no_push", 32'(da_cnt - da0), 32'h0);
      check("parity_bad_rxbuf", RXBUF, model_buf());
      da0 = da_cnt;
      pe0 = pe_cnt;
      send_frame(8'h03, 1'b1, 1'b0);
      pushed.push_back(8'h03);
      tick(2);
      check("parity_good_no_pulse", 32'(pe_cnt - pe0), 32'h0);
      check("parity_good_push", 32'(da_cnt - da0), 32'h1);
      check("parity_good_rxbuf", RXBUF, model_buf());
`endif

      // Random frames against the history model.
      for (int n = 0; n < 24; n++) begin
         d       = 8'($urandom);
         stop_ok = ($urandom_range(0, 4) != 0);
`ifdef UART_RX_PARITY_EN
         par_bad = ($urandom_range(0, 4) == 0);
`else
         par_bad = 1'b0;
`endif
         gap = (stop_ok && !par_bad) ? int'($urandom_range(0, 6)) : int'($urandom_range(4, 12));
         da0 = da_cnt;
         fe0 = fe_cnt;
         pe0 = pe_cnt;
         send_frame(d, stop_ok, par_bad);
         if (stop_ok && !par_bad) pushed.push_back(d);
         tick(gap);
         check($sformatf("rand%0d_rxbuf", n), RXBUF, model_buf());
         check($sformatf("rand%0d_data_available", n), 32'(da_cnt - da0),
               32'((stop_ok && !par_bad) ? 1 : 0));
         check($sformatf("rand%0d_frame_err", n), 32'(fe_cnt - fe0), 32'(stop_ok ? 0 : 1));
         check($sformatf("rand%0d_parity_err", n), 32'(pe_cnt - pe0), 32'(par_bad ? 1 : 0));
      end
      tick(CPB);

      check("pulse_rule_violations", 32'(rule_viol), 32'h0);
`ifndef UART_RX_PARITY_EN
      check("parity_err_never_in_8n1", 32'(pe_cnt), 32'h0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
